// File: rtl/bus_router.sv
// Address-decoding request router: one master, NSLV slaves, single outstanding transaction.
// Latency: s_req one cycle after an accepted m_req; m_resp in the same cycle as the slave response.
// Backpressure: none; a new request is taken only in IDLE or alongside a response, otherwise dropped.

`ifndef XLEN
`define XLEN 32
`endif
`ifndef BUS_WIDTH
`define BUS_WIDTH 32
`endif
`ifndef BUS_ACC_CNT
`define BUS_ACC_CNT 4
`endif

module bus_router #(
    parameter int                      NSLV    = 4,
    parameter logic [NSLV*`XLEN-1:0]   BASE    = {32'h4000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000},
    parameter logic [NSLV*`XLEN-1:0]   MASK    = {4{32'hF000_0000}},
    parameter int                      TIMEOUT = 255
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [`XLEN-1:0]                m_addr,
    input  logic                            m_w_rb,
    input  logic [$clog2(`BUS_ACC_CNT)-1:0] m_acc,
    input  logic [`BUS_WIDTH-1:0]           m_wdata,
    input  logic                            m_req,
    output logic                            m_resp,
    output logic [`BUS_WIDTH-1:0]           m_rdata,
    output logic                            m_fault,
    output logic                            timeout,
    output logic [`XLEN-1:0]                s_addr,
    output logic                            s_w_rb,
    output logic [$clog2(`BUS_ACC_CNT)-1:0] s_acc,
    output logic [`BUS_WIDTH-1:0]           s_wdata,
    output logic [NSLV-1:0]                 s_req,
    input  logic [NSLV-1:0]                 s_resp,
    input  logic [NSLV*`BUS_WIDTH-1:0]      s_rdata
);

    localparam int XL = `XLEN;
    localparam int BW = `BUS_WIDTH;
    localparam int AW = $clog2(`BUS_ACC_CNT);
    localparam int SW = (NSLV > 1) ? $clog2(NSLV) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, ERR} state_t;

    state_t          state;
    logic [SW-1:0]   sel;
    logic [15:0]     cnt;
    logic [NSLV-1:0] s_req_q;

    logic            hit;
    logic [SW-1:0]   hit_idx;
    logic            misalign;
    logic            bad;
    logic            ack;
    logic            expire;
    logic            err_resp;
    logic            accept;
    logic [BW-1:0]   sel_rdata;

    // Region decode; scanning downwards lets the lowest matching index win.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int k = NSLV - 1; k >= 0; k--) begin
            if ((m_addr & MASK[k*XL +: XL]) == BASE[k*XL +: XL]) begin
                hit     = 1'b1;
                hit_idx = SW'(k);
            end
        end
    end

    assign misalign = ((m_acc == AW'(1)) && m_addr[0])
                   || ((m_acc == AW'(2)) && (m_addr[1:0] != 2'b00))
                   || (m_acc > AW'(2));
    assign bad      = !hit || misalign;

    // Response sources; everything is gated by rst so an abandoned transaction never answers.
    assign sel_rdata = s_rdata[sel*BW +: BW];
    assign ack       = !rst && (state == WAIT) && s_resp[sel];
    assign expire    = !rst && (state == WAIT) && !s_resp[sel] && (cnt == 16'(TIMEOUT));
    assign err_resp  = !rst && (state == ERR);

    assign m_resp  = ack || expire || err_resp;
    assign m_rdata = ack ? sel_rdata : '0;
    assign timeout = expire;

    // A request may overlap the response that retires the previous one.
    assign accept  = !rst && m_req && ((state == IDLE) || m_resp);
    assign m_fault = accept && bad;
    assign s_req   = s_req_q & {NSLV{~rst}};

    // Transaction state, selected slave, wait counter and the one-shot slave request.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            s_req_q <= '0;
            cnt     <= '0;
        end else begin
            s_req_q <= '0;
            if (accept) begin
                if (bad) begin
                    state <= ERR;
                end else begin
                    state   <= WAIT;
                    sel     <= hit_idx;
                    cnt     <= '0;
                    s_req_q <= NSLV'(1) << hit_idx;
                end
            end else if (m_resp) begin
                state <= IDLE;
            end else if (state == WAIT) begin
                cnt <= cnt + 16'd1;
            end
        end
    end

    // Request fields broadcast to all slaves; only meaningful alongside s_req, so no reset.
    always_ff @(posedge clk) begin
        if (accept && !bad) begin
            s_addr  <= m_addr;
            s_w_rb  <= m_w_rb;
            s_acc   <= m_acc;
            s_wdata <= m_wdata;
        end
    end

endmodule

// File: tb/tb_bus_router.sv
// Directed bench for bus_router with a transaction-level reference model.
// Latency: model checked every cycle on the falling edge; directed literals checked mid-cycle.
// Backpressure: none; stimulus is fixed-cycle, no open-ended waits.

`ifndef XLEN
`define XLEN 32
`endif
`ifndef BUS_WIDTH
`define BUS_WIDTH 32
`endif
`ifndef BUS_ACC_CNT
`define BUS_ACC_CNT 4
`endif

module tb_bus_router;

    localparam int TO = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  m_addr;
    logic         m_w_rb;
    logic [1:0]   m_acc;
    logic [31:0]  m_wdata;
    logic         m_req;
    logic         m_resp;
    logic [31:0]  m_rdata;
    logic         m_fault;
    logic         timeout;
    logic [31:0]  s_addr;
    logic         s_w_rb;
    logic [1:0]   s_acc;
    logic [31:0]  s_wdata;
    logic [3:0]   s_req;
    logic [3:0]   s_resp;
    logic [127:0] s_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    bus_router #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .m_addr(m_addr), .m_w_rb(m_w_rb), .m_acc(m_acc), .m_wdata(m_wdata),
        .m_req(m_req), .m_resp(m_resp), .m_rdata(m_rdata), .m_fault(m_fault),
        .timeout(timeout),
        .s_addr(s_addr), .s_w_rb(s_w_rb), .s_acc(s_acc), .s_wdata(s_wdata),
        .s_req(s_req), .s_resp(s_resp), .s_rdata(s_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // cur: -1 no transaction, -2 error reply owed, 0..3 slave being waited on.
    logic [31:0] bases [4] = '{32'h0000_0000, 32'h1000_0000, 32'h2000_0000, 32'h4000_0000};
    int          cur    = -1;
    int          waited = 0;
    logic [3:0]  nsreq  = 4'b0;
    logic [31:0] e_addr, e_wdata;
    logic        e_wrb;
    logic [1:0]  e_acc;

    always @(negedge clk) begin
        logic        e_resp, e_to, e_fault, e_bad, e_accept, e_mis;
        logic [31:0] e_rd;
        int          k;
        e_resp = 1'b0; e_to = 1'b0; e_rd = 32'h0;
        if (!rst) begin
            if (cur == -2) e_resp = 1'b1;
            if (cur >= 0) begin
                if (s_resp[cur]) begin
                    e_resp = 1'b1;
                    e_rd   = s_rdata[cur*32 +: 32];
                end else if (waited == TO) begin
                    e_resp = 1'b1;
                    e_to   = 1'b1;
                end
            end
        end
        k = -1;
        for (int i = 3; i >= 0; i--)
            if ((m_addr & 32'hF000_0000) == bases[i]) k = i;
        case (m_acc)
            2'd0:    e_mis = 1'b0;
            2'd1:    e_mis = m_addr[0];
            2'd2:    e_mis = (m_addr[1:0] != 2'b00);
            default: e_mis = 1'b1;
        endcase
        e_bad    = (k < 0) || e_mis;
        e_accept = !rst && m_req && ((cur == -1) || e_resp);
        e_fault  = e_accept && e_bad;

        chk("m_resp", m_resp, e_resp);
        chk("m_rdata", m_rdata, e_rd);
        chk("timeout", timeout, e_to);
        chk("m_fault", m_fault, e_fault);
        chk("s_req", s_req, rst ? 4'b0 : nsreq);
        if (!rst && nsreq != 4'b0) begin
            chk("s_addr", s_addr, e_addr);
            chk("s_w_rb", s_w_rb, e_wrb);
            chk("s_acc", s_acc, e_acc);
            chk("s_wdata", s_wdata, e_wdata);
        end

        if (rst) begin
            cur = -1; waited = 0; nsreq = 4'b0;
        end else begin
            nsreq = 4'b0;
            if (e_accept) begin
                if (e_bad) cur = -2;
                else begin
                    cur = k; waited = 0; nsreq = 4'b1 << k;
                    e_addr = m_addr; e_wrb = m_w_rb; e_acc = m_acc; e_wdata = m_wdata;
                end
            end else if (e_resp) cur = -1;
            else if (cur >= 0) waited++;
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
        m_req = 1'b0; s_resp = 4'b0; s_rdata = '0;
    endtask

    task automatic req(input logic [31:0] a, input logic w, input logic [1:0] acc, input logic [31:0] d);
        m_addr = a; m_w_rb = w; m_acc = acc; m_wdata = d; m_req = 1'b1;
    endtask

    initial begin
        rst = 1'b1; m_addr = '0; m_w_rb = 1'b0; m_acc = 2'd0; m_wdata = '0;
        m_req = 1'b0; s_resp = 4'b0; s_rdata = '0;
        repeat (2) @(posedge clk);
        #3;
        chk("rst_m_resp", m_resp, 1'b0);
        chk("rst_s_req", s_req, 4'b0);
        chk("rst_timeout", timeout, 1'b0);
        chk("rst_m_fault", m_fault, 1'b0);
        step(); rst = 1'b0;

        // Word read to slave 1, answered three cycles later; stray slave-0 response ignored.
        step(); req(32'h1000_0010, 1'b0, 2'd2, 32'h0); #2;
        chk("rd_fault", m_fault, 1'b0);
        step(); #2;
        chk("rd_sreq", s_req, 4'b0010);
        chk("rd_saddr", s_addr, 32'h1000_0010);
        step(); s_resp = 4'b0001; s_rdata[31:0] = 32'h1111_1111; #2;
        chk("rd_stray", m_resp, 1'b0);
        step(); s_resp = 4'b0010; s_rdata[63:32] = 32'hDEAD_BEEF; #2;
        chk("rd_resp", m_resp, 1'b1);
        chk("rd_rdata", m_rdata, 32'hDEAD_BEEF);

        // Unmapped read.
        step(); req(32'h8000_0000, 1'b0, 2'd2, 32'h0); #2;
        chk("unm_fault", m_fault, 1'b1);
        step(); #2;
        chk("unm_resp", m_resp, 1'b1);
        chk("unm_rdata", m_rdata, 32'h0);
        chk("unm_sreq", s_req, 4'b0);

        // Misaligned half-word write.
        step(); req(32'h2000_0001, 1'b1, 2'd1, 32'h1234); #2;
        chk("mis_fault", m_fault, 1'b1);
        step(); #2;
        chk("mis_resp", m_resp, 1'b1);

        // Illegal access size, then a request accepted in the error-reply cycle.
        step(); req(32'h1000_0000, 1'b0, 2'd3, 32'h0); #2;
        chk("acc3_fault", m_fault, 1'b1);
        step(); req(32'h0000_0003, 1'b0, 2'd0, 32'h0); #2;
        chk("err_overlap_resp", m_resp, 1'b1);
        chk("err_overlap_fault", m_fault, 1'b0);
        step(); #2;
        chk("byte_sreq", s_req, 4'b0001);
        step(); s_resp = 4'b0001; s_rdata[31:0] = 32'h0000_00AB; #2;
        chk("byte_rdata", m_rdata, 32'h0000_00AB);

        // Timeout on slave 0; a request during WAIT is dropped.
        step(); req(32'h0000_0100, 1'b0, 2'd2, 32'h0);
        step(); #2;
        chk("to_sreq", s_req, 4'b0001);
        step(); req(32'h4000_0000, 1'b0, 2'd2, 32'h0); #2;
        chk("viol_fault", m_fault, 1'b0);
        step(); #2;
        chk("viol_sreq", s_req, 4'b0);
        step(); #2;
        chk("to_early", m_resp, 1'b0);
        step(); s_rdata[31:0] = 32'hFFFF_FFFF; #2;
        chk("to_resp", m_resp, 1'b1);
        chk("to_flag", timeout, 1'b1);
        chk("to_rdata", m_rdata, 32'h0);

        // Back-to-back: slave 2 answers while a write to slave 3 is issued.
        step(); req(32'h2000_0004, 1'b0, 2'd2, 32'h0);
        step(); #2;
        chk("b2b_sreq2", s_req, 4'b0100);
        step(); s_resp = 4'b0100; s_rdata[95:64] = 32'h1234_5678;
        req(32'h4000_0008, 1'b1, 2'd2, 32'hCAFE_F00D); #2;
        chk("b2b_resp", m_resp, 1'b1);
        chk("b2b_rdata", m_rdata, 32'h1234_5678);
        step(); #2;
        chk("b2b_sreq3", s_req, 4'b1000);
        chk("b2b_wdata", s_wdata, 32'hCAFE_F00D);
        step(); s_resp = 4'b1000; s_rdata[127:96] = 32'h0000_55AA; #2;
        chk("b2b_resp3", m_rdata, 32'h0000_55AA);

        // Reset during WAIT abandons the transaction.
        step(); req(32'h1000_0020, 1'b0, 2'd2, 32'h0);
        step(); #2;
        chk("rw_sreq", s_req, 4'b0010);
        step(); rst = 1'b1; #2;
        chk("rw_rst_resp", m_resp, 1'b0);
        step(); rst = 1'b0; s_resp = 4'b0010; s_rdata[63:32] = 32'hAAAA_AAAA; #2;
        chk("rw_late_resp", m_resp, 1'b0);
        chk("rw_late_rdata", m_rdata, 32'h0);
        step(); req(32'h1000_0024, 1'b0, 2'd2, 32'h0);
        step(); #2;
        chk("rw_next_sreq", s_req, 4'b0010);
        step(); s_resp = 4'b0010; s_rdata[63:32] = 32'h0BAD_CAFE; #2;
        chk("rw_next_rdata", m_rdata, 32'h0BAD_CAFE);

        step(); step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bus_router.md
BUS_ROUTER -- requirements
Module: bus_router

Interface
REQ-001 Parameter NSLV, default 4: number of slave ports.
REQ-002 Parameter BASE, default {32'h4000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000}: flattened NSLV x `XLEN region bases, slave 0 in the LSBs.
REQ-003 Parameter MASK, default {4{32'hF000_0000}}: flattened NSLV x `XLEN region masks.
REQ-004 Parameter TIMEOUT, default 255: maximum WAIT cycles before a forced response; legal range 1..65535.
REQ-005 clk  in  1  clock; all state updates on its rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 m_addr  in  `XLEN  byte address, valid with m_req.
REQ-008 m_w_rb  in  1  1 = write, 0 = read.
REQ-009 m_acc  in  $clog2(`BUS_ACC_CNT)  access size: 0 byte, 1 half, 2 word.
REQ-010 m_wdata  in  `BUS_WIDTH  write data.
REQ-011 m_req  in  1  single-cycle request pulse.
REQ-012 m_resp  out  1  single-cycle response pulse.
REQ-013 m_rdata  out  `BUS_WIDTH  read data, valid with m_resp.
REQ-014 m_fault  out  1  combinational decode fault, valid in the m_req cycle.
REQ-015 timeout  out  1  single-cycle pulse, coincident with a forced m_resp.
REQ-016 s_addr, s_w_rb, s_acc, s_wdata  out  same widths as m_*  registered request fields, broadcast to all slaves.
REQ-017 s_req  out  NSLV  one-hot request pulse.
REQ-018 s_resp  in  NSLV  per-slave response pulses.
REQ-019 s_rdata  in  NSLV x `BUS_WIDTH  flattened per-slave read data.

Function
REQ-020 Slave k SHALL match when (m_addr & MASK[k]) == BASE[k]; if several slaves match, the lowest index SHALL win.
REQ-021 The request SHALL be misaligned when (m_acc==1 and m_addr[0]) or (m_acc==2 and m_addr[1:0]!=0) or m_acc>2.
REQ-022 States SHALL be IDLE, WAIT and ERR; a request is accepted in IDLE, or in any cycle where m_resp=1.
REQ-023 Accepted m_req with no match or misaligned: m_fault=1 combinationally in the same cycle; next state ERR; no s_req is issued.
REQ-024 ERR SHALL last one cycle, with m_resp=1 and m_rdata=0; next state IDLE, unless a concurrent request is accepted.
REQ-025 Accepted, decodable m_req at cycle T: the s_* fields SHALL be registered from m_*; the selected slave index SHALL be registered; s_req[sel] SHALL pulse at T+1; state WAIT is entered at T+1.
REQ-026 In WAIT, s_resp[sel]=1 SHALL drive m_resp=1 and m_rdata=s_rdata[sel] combinationally in the same cycle; next state IDLE, unless a concurrent request is accepted.
REQ-027 s_resp from non-selected slaves, and any s_resp in IDLE or ERR, SHALL be ignored.
REQ-028 A 16-bit counter SHALL clear on WAIT entry and increment on every WAIT cycle.
REQ-029 In a WAIT cycle where the counter equals TIMEOUT and s_resp[sel]=0: m_resp=1, m_rdata=0, timeout=1; next state IDLE, unless a concurrent request is accepted.
REQ-030 A stale response from a timed-out slave is not filtered.
REQ-031 m_req while in WAIT or ERR with m_resp=0 is a protocol violation and SHALL be ignored.
REQ-032 m_rdata SHALL be 0 whenever m_resp=0; m_fault SHALL be 0 outside accepted-request cycles.

Reset
REQ-033 While rst=1: state=IDLE, s_req=0, counter=0, m_resp=0, m_fault=0, timeout=0; s_addr, s_w_rb, s_acc and s_wdata are not reset.
REQ-034 Reset during WAIT or ERR SHALL abandon the transaction; no m_resp SHALL be produced for it.

Verification
REQ-035 Word read at 0x1000_0010, cycle T; slave 1 responds at T+3 with 0xDEAD_BEEF -> s_req=4'b0010 at T+1; m_resp=1 with m_rdata=0xDEAD_BEEF at T+3.
REQ-036 Read at 0x8000_0000 (unmapped) -> m_fault=1 at T; m_resp=1, m_rdata=0 at T+1; no s_req pulse.
REQ-037 Half-word write at 0x2000_0001 -> m_fault=1 at T; m_resp=1 at T+1.
REQ-038 TIMEOUT=4, slave 0 never responds -> s_req=4'b0001 at T+1; m_resp=1, timeout=1, m_rdata=0 at T+5.
REQ-039 Second m_req (to slave 3) in the same cycle as slave 2's s_resp -> both accepted; s_req=4'b1000 in the next cycle.
REQ-040 rst asserted during WAIT with s_resp arriving one cycle later -> m_resp stays 0; the next request completes normally.
